dem_tree_sched: RTL and testbench

DEM_TREE_SCHED -- requirements
Module: dem_tree_sched

---
 rtl/dem_pkg.sv | 14 +
 rtl/dem_split_core.sv | 27 ++
 rtl/dem_tree_sched.sv | 113 +++++++++++
 tb/tb_dem_tree_sched.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/dem_pkg.sv
// dem_pkg: shared types and constants for the tree DEM scheduler and its split core.
package dem_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ROOT, S_LEFT, S_RIGHT, S_DONE} state_t;
  localparam int N_ROOT = 0;
  localparam int N_LEFT = 1;
  localparam int N_RIGHT = 2;
  localparam int DEF_L_ROOT = 4;
  localparam int DEF_L_LEAF = 2;
  typedef struct packed {
    logic [5:0] vd;
    logic [1:0] lfd;
    logic [1:0] lod;
  } node_st_t;
endpackage

// File: rtl/dem_split_core.sv
// dem_split_core: combinational split of one tree node into Gama/Beta with dithered first-order shaping.
module dem_split_core (
  input  logic [5:0] v,
  input  logic [5:0] vd,
  input  logic [1:0] lfd,
  input  logic [1:0] lod,
  input  logic [1:0] dither,
  input  logic [5:0] l,
  output logic [3:0] gama,
  output logic [4:0] beta,
  output logic [1:0] lf,
  output logic [1:0] lo
);
  logic [5:0] w_vdiff, w_ka;
  logic [2:0] w_ld;
  logic       w_sel;
  always_comb begin
    w_vdiff = v - vd;
    w_sel = w_vdiff[0] ^ l[0];
    lf = lfd - lod;
    w_ld = {dither[1], dither} + {lf[1], lf};
    lo = w_sel ? (w_ld[2] ? 2'b11 : 2'b01) : 2'b00;
    w_ka = {{4{lo[1]}}, lo} + l + w_vdiff;
    gama = 4'(w_ka >> 1);
    beta = v[4:0] - {1'b0, gama};
  end
endmodule

// File: rtl/dem_tree_sched.sv
// dem_tree_sched: time-shares one split core over the root and two leaf nodes,
// producing four group counts per accepted thermometer code.
module dem_tree_sched
  import dem_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          L_ROOT    = DEF_L_ROOT,
  parameter int          L_LEAF    = DEF_L_LEAF
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [5:0] in_code,
  input  logic       cfg_dither_en,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] q0,
  output logic [3:0] q1,
  output logic [3:0] q2,
  output logic [3:0] q3,
  output logic       err_ovr
);
  state_t     r_state, w_next;
  node_st_t   r_bank [3];
  node_st_t   w_cur;
  logic [15:0] r_lfsr;
  logic [4:0] r_code, r_rb;
  logic [3:0] r_rg;
  logic [1:0] w_node, w_dither, w_lf, w_lo;
  logic [5:0] w_v, w_l;
  logic [3:0] w_gama;
  logic [4:0] w_beta;
  logic       w_accept, w_eval, w_fb;

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_state <= S_IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  w_next = w_accept ? S_ROOT : S_IDLE;
      S_ROOT:  w_next = S_LEFT;
      S_LEFT:  w_next = S_RIGHT;
      S_RIGHT: w_next = S_DONE;
      S_DONE:  w_next = w_accept ? S_ROOT : (out_ready ? S_IDLE : S_DONE);
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
    out_valid = r_state == S_DONE;
    w_accept = in_valid & in_ready;
    w_eval = (r_state == S_ROOT) | (r_state == S_LEFT) | (r_state == S_RIGHT);
    w_node = (r_state == S_LEFT) ? 2'(N_LEFT) : (r_state == S_RIGHT) ? 2'(N_RIGHT) : 2'(N_ROOT);
    w_v = (r_state == S_ROOT) ? {1'b0, r_code} : (r_state == S_LEFT) ? {2'b0, r_rg} : {1'b0, r_rb};
    w_l = (r_state == S_ROOT) ? 6'(L_ROOT) : 6'(L_LEAF);
    w_dither = cfg_dither_en ? (r_lfsr[0] ? 2'b11 : 2'b01) : 2'b00;
    w_cur = r_bank[w_node];
    w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  end

  dem_split_core u_core (
    .v      (w_v),
    .vd     (w_cur.vd),
    .lfd    (w_cur.lfd),
    .lod    (w_cur.lod),
    .dither (w_dither),
    .l      (w_l),
    .gama   (w_gama),
    .beta   (w_beta),
    .lf     (w_lf),
    .lo     (w_lo)
  );

  // Root results are parked in r_rg/r_rb and become the leaf inputs on the next two cycles.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_code <= '0;
      r_rg <= '0;
      r_rb <= '0;
      r_lfsr <= LFSR_SEED;
      for (int i = 0; i < 3; i++) r_bank[i] <= '0;
      q0 <= '0;
      q1 <= '0;
      q2 <= '0;
      q3 <= '0;
      err_ovr <= 1'b0;
    end else begin
      if (w_accept) begin
        r_code <= (in_code > 6'd16) ? 5'd16 : in_code[4:0];
        err_ovr <= err_ovr | (in_code > 6'd16);
      end
      if (w_eval) begin
        r_bank[w_node] <= '{vd: w_v, lfd: w_lf, lod: w_lo};
        r_lfsr <= {r_lfsr[14:0], w_fb};
      end
      if (r_state == S_ROOT) begin
        r_rg <= w_gama;
        r_rb <= w_beta;
      end
      if (r_state == S_LEFT) begin
        q0 <= w_gama;
        q1 <= w_beta[3:0];
      end
      if (r_state == S_RIGHT) begin
        q2 <= w_gama;
        q3 <= w_beta[3:0];
      end
    end
endmodule

// File: tb/tb_dem_tree_sched.sv
// tb_dem_tree_sched: scoreboard bench for dem_tree_sched against an integer reference model.
module tb_dem_tree_sched;
  localparam int L_ROOT = 4;
  localparam int L_LEAF = 2;
  localparam logic [15:0] SEED = 16'hACE1;

  typedef struct packed {
    int          acc;
    logic [15:0] q;
  } exp_t;

  logic       clk, rstn, in_valid, in_ready, cfg_dither_en, out_valid, out_ready, err_ovr;
  logic [5:0] in_code;
  logic [3:0] q0, q1, q2, q3;
  logic       rnd_ready, prev_ov;
  int         cyc, n_chk, n_fail;
  exp_t       sb[$];
  int         m_vd[3], m_lfd[3], m_lod[3];
  logic [15:0] m_lfsr;

  dem_tree_sched dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .cfg_dither_en(cfg_dither_en), .out_valid(out_valid), .out_ready(out_ready),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3), .err_ovr(err_ovr)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 3; i++) begin
      m_vd[i] = 0;
      m_lfd[i] = 0;
      m_lod[i] = 0;
    end
    m_lfsr = SEED;
  endtask

  // One node split with plain integer arithmetic, wrapping at the stated bit widths.
  task automatic m_node(input int v, input int l, input int n, input bit den, output int g, output int b);
    int vdiff, lf, lfs, d, ld, lo, ka;
    vdiff = (v - m_vd[n]) & 63;
    lf = (m_lfd[n] - m_lod[n]) & 3;
    lfs = (lf >= 2) ? lf - 4 : lf;
    d = den ? (m_lfsr[0] ? -1 : 1) : 0;
    ld = d + lfs;
    lo = ((vdiff ^ l) & 1) ? ((ld < 0) ? -1 : 1) : 0;
    ka = (lo + l + vdiff) & 63;
    g = (ka >> 1) & 15;
    b = ((v & 31) - g) & 31;
    m_vd[n] = v;
    m_lfd[n] = lf;
    m_lod[n] = lo & 3;
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  endtask

  task automatic m_sample(input int code, input bit den, output logic [15:0] q);
    int c, rg, rb, g0, b0, g1, b1;
    c = (code > 16) ? 16 : code;
    m_node(c, L_ROOT, 0, den, rg, rb);
    m_node(rg, L_LEAF, 1, den, g0, b0);
    m_node(rb, L_LEAF, 2, den, g1, b1);
    q = {4'(b1), 4'(g1), 4'(b0), 4'(g0)};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input int code);
    bit   got;
    exp_t e;
    in_valid = 1;
    in_code = 6'(code);
    got = 0;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      if (in_ready) got = 1;
      else step();
    end
    if (!got) chk("accept_timeout", 0, 1);
    else begin
      m_sample(code, cfg_dither_en, e.q);
      e.acc = cyc;
      sb.push_back(e);
    end
    step();
    in_valid = 0;
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && sb.size() != 0; t++) step();
    chk("drain_left", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rstn) prev_ov = 0;
    else begin
      if (out_valid) begin
        if (sb.size() == 0) chk("out_without_sample", 1, 0);
        else begin
          if (!prev_ov) chk("latency", cyc - sb[0].acc, 4);
          chk("q3q2q1q0", {q3, q2, q1, q0}, sb[0].q);
          if (out_ready) void'(sb.pop_front());
        end
      end
      prev_ov = out_valid && !out_ready;
    end
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    rstn = 0;
    in_valid = 0;
    in_code = 0;
    cfg_dither_en = 0;
    out_ready = 1;
    rnd_ready = 0;
    prev_ov = 0;
    m_reset();
    step();
    step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_q", {q3, q2, q1, q0}, 0);
    chk("rst_err", err_ovr, 0);
    rstn = 1;
    step();
    send(16);
    drain();
    for (int i = 0; i < 10; i++) send(0);
    drain();
    chk("err_after_zeros", err_ovr, 0);
    send(20);
    drain();
    chk("err_set", err_ovr, 1);
    send(7);
    send(16);
    drain();
    chk("err_sticky", err_ovr, 1);
    // Backpressure: output held, a pending in_valid must wait for out_ready.
    out_ready = 0;
    send(5);
    in_valid = 1;
    in_code = 6'd9;
    for (int t = 0; t < 8 && !out_valid; t++) step();
    chk("bp_out_valid", out_valid, 1);
    repeat (6) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      step();
    end
    out_ready = 1;
    send(9);
    drain();
    // Randomized run with dither on and random downstream stalls.
    cfg_dither_en = 1;
    rnd_ready = 1;
    for (int i = 0; i < 10000; i++) send($urandom_range(0, 16));
    rnd_ready = 0;
    out_ready = 1;
    drain();
    // Reset in the middle of a sample while the LEFT node is being evaluated.
    send(11);
    step();
    rstn = 0;
    sb.delete();
    m_reset();
    #2;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_err", err_ovr, 0);
    step();
    rstn = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrst_no_out", out_valid, 0);
      step();
    end
    send(11);
    send(3);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
